// File: rtl/hazard_controller_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package hazard_controller_pkg;

    // Sequencer state: normal flow, or waiting for an outstanding cache access.
    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    // Operand source selects for the execute stage.
    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // The memory stage holds the younger result, so it beats writeback.
    function automatic logic [1:0] fwd_pick(input logic mem_hit, input logic wb_hit);
        logic [1:0] sel;
        sel = FWD_RF;
        if (mem_hit) begin
            sel = FWD_MEM;
        end else if (wb_hit) begin
            sel = FWD_WB;
        end
        return sel;
    endfunction

endpackage

// File: rtl/hazard_controller_forward_unit.sv
// Operand forwarding selects for both execute-stage source registers.
module forward_unit
    import hazard_controller_pkg::*;
#(
    parameter int REG_ADDR_W = 5
) (
    input  logic [REG_ADDR_W-1:0] rs1_addr_exec,
    input  logic [REG_ADDR_W-1:0] rs2_addr_exec,
    input  logic [REG_ADDR_W-1:0] rd_addr_mem,
    input  logic                  reg_we_mem,
    input  logic [REG_ADDR_W-1:0] rd_addr_wb,
    input  logic                  reg_we_wb,
    output logic [1:0]            fwd_rs1_sel,
    output logic [1:0]            fwd_rs2_sel
);

    logic [REG_ADDR_W-1:0] src_addr [2];
    logic [1:0]            src_sel  [2];
    logic                  mem_valid;
    logic                  wb_valid;

    // x0 is hard-wired to zero, so a write to it never produces a forwardable value.
    assign mem_valid = reg_we_mem && (rd_addr_mem != '0);
    assign wb_valid  = reg_we_wb  && (rd_addr_wb  != '0);

    assign src_addr[0] = rs1_addr_exec;
    assign src_addr[1] = rs2_addr_exec;

    // Identical comparison logic for each source operand.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src
            logic mem_hit;
            logic wb_hit;
            assign mem_hit     = mem_valid && (rd_addr_mem == src_addr[gi]);
            assign wb_hit      = wb_valid  && (rd_addr_wb  == src_addr[gi]);
            assign src_sel[gi] = fwd_pick(mem_hit, wb_hit);
        end
    endgenerate

    assign fwd_rs1_sel = src_sel[0];
    assign fwd_rs2_sel = src_sel[1];

endmodule

// File: rtl/hazard_controller.sv
// Pipeline sequencer: memory-wait FSM, stall/flush generation, forwarding
// selects and saturating stall/flush performance counters.
module hazard_controller
    import hazard_controller_pkg::*;
#(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                  i_clk,
    input  logic                  i_arst,
    input  logic [REG_ADDR_W-1:0] i_rs1_addr_dec,
    input  logic [REG_ADDR_W-1:0] i_rs2_addr_dec,
    input  logic [REG_ADDR_W-1:0] i_rs1_addr_exec,
    input  logic [REG_ADDR_W-1:0] i_rs2_addr_exec,
    input  logic [REG_ADDR_W-1:0] i_rd_addr_exec,
    input  logic                  i_reg_we_exec,
    input  logic                  i_load_instr_exec,
    input  logic                  i_pc_redirect_exec,
    input  logic [REG_ADDR_W-1:0] i_rd_addr_mem,
    input  logic                  i_reg_we_mem,
    input  logic                  i_mem_access_mem,
    input  logic                  i_mem_ready,
    input  logic [REG_ADDR_W-1:0] i_rd_addr_wb,
    input  logic                  i_reg_we_wb,
    output logic                  o_stall_fetch,
    output logic                  o_stall_dec,
    output logic                  o_flush_dec,
    output logic                  o_stall_exec,
    output logic                  o_flush_exec,
    output logic                  o_stall_mem,
    output logic [1:0]            o_fwd_rs1_sel,
    output logic [1:0]            o_fwd_rs2_sel,
    output logic                  o_busy,
    output logic [CNT_WIDTH-1:0]  o_stall_cycles,
    output logic [CNT_WIDTH-1:0]  o_flush_count
);

    state_t                state_reg;
    state_t                state_next;
    logic [CNT_WIDTH-1:0]  stall_cycles_reg;
    logic [CNT_WIDTH-1:0]  flush_count_reg;

    logic                  mem_stall;
    logic                  load_use;
    logic                  redirect_flush;
    logic [1:0]            fwd_rs1_raw;
    logic [1:0]            fwd_rs2_raw;

    // Forwarding is purely a function of the exec/mem/wb register addresses.
    forward_unit #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_forward_unit (
        .rs1_addr_exec (i_rs1_addr_exec),
        .rs2_addr_exec (i_rs2_addr_exec),
        .rd_addr_mem   (i_rd_addr_mem),
        .reg_we_mem    (i_reg_we_mem),
        .rd_addr_wb    (i_rd_addr_wb),
        .reg_we_wb     (i_reg_we_wb),
        .fwd_rs1_sel   (fwd_rs1_raw),
        .fwd_rs2_sel   (fwd_rs2_raw)
    );

    // A cache miss stalls from its first cycle; i_mem_ready releases with no extra latency.
    assign mem_stall = !i_mem_ready &&
                       ((state_reg == MEM_WAIT) || i_mem_access_mem);

    // Load result is not available until memory, so a dependent decode must wait one cycle.
    assign load_use = i_load_instr_exec && i_reg_we_exec && (i_rd_addr_exec != '0) &&
                      ((i_rd_addr_exec == i_rs1_addr_dec) ||
                       (i_rd_addr_exec == i_rs2_addr_dec));

    // Priority: reset, memory stall, redirect, load-use.
    always_comb begin
        state_next     = mem_stall ? MEM_WAIT : RUN;
        o_stall_fetch  = 1'b0;
        o_stall_dec    = 1'b0;
        o_stall_exec   = 1'b0;
        o_stall_mem    = 1'b0;
        o_flush_dec    = 1'b0;
        o_flush_exec   = 1'b0;
        o_fwd_rs1_sel  = FWD_RF;
        o_fwd_rs2_sel  = FWD_RF;
        o_busy         = 1'b0;
        redirect_flush = 1'b0;
        if (i_arst) begin
            state_next   = RUN;
            o_flush_dec  = 1'b1;
            o_flush_exec = 1'b1;
        end else begin
            o_fwd_rs1_sel = fwd_rs1_raw;
            o_fwd_rs2_sel = fwd_rs2_raw;
            o_busy        = (state_reg == MEM_WAIT);
            if (mem_stall) begin
                // Whole pipe frozen; pending redirect/load-use stays in the exec register.
                o_stall_fetch = 1'b1;
                o_stall_dec   = 1'b1;
                o_stall_exec  = 1'b1;
                o_stall_mem   = 1'b1;
            end else if (i_pc_redirect_exec) begin
                // Squashes the dependent instruction, so load-use is moot.
                o_flush_dec    = 1'b1;
                o_flush_exec   = 1'b1;
                redirect_flush = 1'b1;
            end else if (load_use) begin
                o_stall_fetch = 1'b1;
                o_stall_dec   = 1'b1;
                o_flush_exec  = 1'b1;
            end
        end
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            state_reg <= RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    // Saturating performance counters.
    always_ff @(posedge i_clk) begin
        if (i_arst) begin
            stall_cycles_reg <= '0;
            flush_count_reg  <= '0;
        end else begin
            if (o_stall_dec && (stall_cycles_reg != '1)) begin
                stall_cycles_reg <= stall_cycles_reg + 1'b1;
            end
            if (redirect_flush && (flush_count_reg != '1)) begin
                flush_count_reg <= flush_count_reg + 1'b1;
            end
        end
    end

    assign o_stall_cycles = stall_cycles_reg;
    assign o_flush_count  = flush_count_reg;

endmodule

// File: tb/tb_hazard_controller.sv
// Directed testbench for hazard_controller: a vector table for the
// single-cycle behaviour plus hand-written multi-cycle sequences.
module tb_hazard_controller;

    localparam int AW = 5;
    localparam int CW = 4;   // narrow counters so saturation is reachable

    logic          i_clk = 1'b0;
    logic          i_arst;
    logic [AW-1:0] i_rs1_addr_dec, i_rs2_addr_dec, i_rs1_addr_exec, i_rs2_addr_exec;
    logic [AW-1:0] i_rd_addr_exec, i_rd_addr_mem, i_rd_addr_wb;
    logic          i_reg_we_exec, i_load_instr_exec, i_pc_redirect_exec;
    logic          i_reg_we_mem, i_mem_access_mem, i_mem_ready, i_reg_we_wb;
    logic          o_stall_fetch, o_stall_dec, o_flush_dec, o_stall_exec, o_flush_exec, o_stall_mem;
    logic [1:0]    o_fwd_rs1_sel, o_fwd_rs2_sel;
    logic          o_busy;
    logic [CW-1:0] o_stall_cycles, o_flush_count;

    int errors = 0;
    int checks = 0;

    always #5 i_clk = ~i_clk;

    hazard_controller #(.REG_ADDR_W(AW), .CNT_WIDTH(CW)) dut (
        .i_clk              (i_clk),
        .i_arst             (i_arst),
        .i_rs1_addr_dec     (i_rs1_addr_dec),
        .i_rs2_addr_dec     (i_rs2_addr_dec),
        .i_rs1_addr_exec    (i_rs1_addr_exec),
        .i_rs2_addr_exec    (i_rs2_addr_exec),
        .i_rd_addr_exec     (i_rd_addr_exec),
        .i_reg_we_exec      (i_reg_we_exec),
        .i_load_instr_exec  (i_load_instr_exec),
        .i_pc_redirect_exec (i_pc_redirect_exec),
        .i_rd_addr_mem      (i_rd_addr_mem),
        .i_reg_we_mem       (i_reg_we_mem),
        .i_mem_access_mem   (i_mem_access_mem),
        .i_mem_ready        (i_mem_ready),
        .i_rd_addr_wb       (i_rd_addr_wb),
        .i_reg_we_wb        (i_reg_we_wb),
        .o_stall_fetch      (o_stall_fetch),
        .o_stall_dec        (o_stall_dec),
        .o_flush_dec        (o_flush_dec),
        .o_stall_exec       (o_stall_exec),
        .o_flush_exec       (o_flush_exec),
        .o_stall_mem        (o_stall_mem),
        .o_fwd_rs1_sel      (o_fwd_rs1_sel),
        .o_fwd_rs2_sel      (o_fwd_rs2_sel),
        .o_busy             (o_busy),
        .o_stall_cycles     (o_stall_cycles),
        .o_flush_count      (o_flush_count)
    );

    typedef struct {
        string         name;
        logic [AW-1:0] rs1_dec, rs2_dec, rs1_exec, rs2_exec, rd_exec;
        logic          we_exec, load_exec, redirect;
        logic [AW-1:0] rd_mem;
        logic          we_mem;
        logic [AW-1:0] rd_wb;
        logic          we_wb;
        logic [3:0]    exp_stall;   // {fetch, dec, exec, mem}
        logic [1:0]    exp_flush;   // {dec, exec}
        logic [1:0]    exp_fwd1, exp_fwd2;
    } vec_t;

    vec_t vecs [11];

    function automatic logic [3:0] stalls();
        return {o_stall_fetch, o_stall_dec, o_stall_exec, o_stall_mem};
    endfunction

    function automatic logic [1:0] flushes();
        return {o_flush_dec, o_flush_exec};
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        i_rs1_addr_dec = '0; i_rs2_addr_dec = '0; i_rs1_addr_exec = '0; i_rs2_addr_exec = '0;
        i_rd_addr_exec = '0; i_reg_we_exec = 0; i_load_instr_exec = 0; i_pc_redirect_exec = 0;
        i_rd_addr_mem = '0; i_reg_we_mem = 0; i_mem_access_mem = 0; i_mem_ready = 1;
        i_rd_addr_wb = '0; i_reg_we_wb = 0;
    endtask

    // Advance one clock; inputs change 1 time unit after the rising edge.
    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        idle_inputs();
        i_arst = 1;
        tick();
        i_arst = 0;
    endtask

    function automatic vec_t mk(string n, int r1d, int r2d, int r1e, int r2e, int rde,
                                bit wee, bit lde, bit rdr, int rdm, bit wem, int rdw, bit wew,
                                logic [3:0] es, logic [1:0] ef, logic [1:0] f1, logic [1:0] f2);
        vec_t v;
        v.name = n; v.rs1_dec = AW'(r1d); v.rs2_dec = AW'(r2d); v.rs1_exec = AW'(r1e);
        v.rs2_exec = AW'(r2e); v.rd_exec = AW'(rde); v.we_exec = wee; v.load_exec = lde;
        v.redirect = rdr; v.rd_mem = AW'(rdm); v.we_mem = wem; v.rd_wb = AW'(rdw); v.we_wb = wew;
        v.exp_stall = es; v.exp_flush = ef; v.exp_fwd1 = f1; v.exp_fwd2 = f2;
        return v;
    endfunction

    initial begin
        //            name          r1d r2d r1e r2e rde we ld rd rdm wem rdw wew stall    flush  fwd1   fwd2
        vecs[0]  = mk("idle",        0,  0,  0,  0,  0, 0, 0, 0,  0, 0,  0, 0, 4'b0000, 2'b00, 2'b00, 2'b00);
        vecs[1]  = mk("lu_rs2_x5",   1,  5,  0,  0,  5, 1, 1, 0,  0, 0,  0, 0, 4'b1100, 2'b01, 2'b00, 2'b00);
        vecs[2]  = mk("lu_rd_x0",    0,  0,  0,  0,  0, 1, 1, 0,  0, 0,  0, 0, 4'b0000, 2'b00, 2'b00, 2'b00);
        vecs[3]  = mk("lu_no_we",    1,  5,  0,  0,  5, 0, 1, 0,  0, 0,  0, 0, 4'b0000, 2'b00, 2'b00, 2'b00);
        vecs[4]  = mk("alu_dep",     5,  2,  0,  0,  5, 1, 0, 0,  0, 0,  0, 0, 4'b0000, 2'b00, 2'b00, 2'b00);
        vecs[5]  = mk("redir_lu",    1,  5,  0,  0,  5, 1, 1, 1,  0, 0,  0, 0, 4'b0000, 2'b11, 2'b00, 2'b00);
        vecs[6]  = mk("fwd_mem_wb",  0,  0,  7,  3,  0, 0, 0, 0,  7, 1,  7, 1, 4'b0000, 2'b00, 2'b10, 2'b00);
        vecs[7]  = mk("fwd_wb_only", 0,  0,  7,  3,  0, 0, 0, 0,  7, 0,  7, 1, 4'b0000, 2'b00, 2'b01, 2'b00);
        vecs[8]  = mk("fwd_x0",      0,  0,  0,  0,  0, 0, 0, 0,  0, 1,  0, 1, 4'b0000, 2'b00, 2'b00, 2'b00);
        vecs[9]  = mk("fwd_split",   0,  0,  4,  9,  0, 0, 0, 0,  4, 1,  9, 1, 4'b0000, 2'b00, 2'b10, 2'b01);
        vecs[10] = mk("lu_rs1_x12", 12,  3,  0,  0, 12, 1, 1, 0,  0, 0,  0, 0, 4'b1100, 2'b01, 2'b00, 2'b00);

        idle_inputs();
        i_arst = 1;
        #1;

        // Reset outputs while reset is held, even with a forwarding match present.
        i_rs1_addr_exec = 5'd7; i_rd_addr_mem = 5'd7; i_reg_we_mem = 1;
        i_mem_access_mem = 1; i_mem_ready = 0;
        @(negedge i_clk);
        check("rst_flush", {6'd0, flushes()}, 8'h03);
        check("rst_stall", {4'd0, stalls()}, 8'h00);
        check("rst_busy_fwd", {3'd0, o_busy, o_fwd_rs1_sel, o_fwd_rs2_sel}, 8'h00);
        tick();
        i_arst = 0;
        idle_inputs();
        #1;
        check("rst_stall_cnt", 8'(o_stall_cycles), 8'd0);
        check("rst_flush_cnt", 8'(o_flush_count), 8'd0);

        // Table-driven single-cycle vectors (RUN state, no memory access).
        for (int i = 0; i < 11; i++) begin
            i_rs1_addr_dec = vecs[i].rs1_dec;   i_rs2_addr_dec = vecs[i].rs2_dec;
            i_rs1_addr_exec = vecs[i].rs1_exec; i_rs2_addr_exec = vecs[i].rs2_exec;
            i_rd_addr_exec = vecs[i].rd_exec;   i_reg_we_exec = vecs[i].we_exec;
            i_load_instr_exec = vecs[i].load_exec; i_pc_redirect_exec = vecs[i].redirect;
            i_rd_addr_mem = vecs[i].rd_mem;     i_reg_we_mem = vecs[i].we_mem;
            i_rd_addr_wb = vecs[i].rd_wb;       i_reg_we_wb = vecs[i].we_wb;
            @(negedge i_clk);
            check({vecs[i].name, "_stall"}, {4'd0, stalls()}, {4'd0, vecs[i].exp_stall});
            check({vecs[i].name, "_flush"}, {6'd0, flushes()}, {6'd0, vecs[i].exp_flush});
            check({vecs[i].name, "_fwd"}, {3'd0, o_busy, o_fwd_rs1_sel, o_fwd_rs2_sel},
                  {3'd0, 1'b0, vecs[i].exp_fwd1, vecs[i].exp_fwd2});
            $display("vec %0d %s: stall=%b flush=%b fwd=%b/%b", i, vecs[i].name,
                     stalls(), flushes(), o_fwd_rs1_sel, o_fwd_rs2_sel);
            tick();
        end
        idle_inputs();
        #1;
        // Two load-use cycles and one redirect cycle in the table.
        check("tbl_stall_cnt", 8'(o_stall_cycles), 8'd2);
        check("tbl_flush_cnt", 8'(o_flush_count), 8'd1);

        // Four-cycle cache miss, released in the ready cycle.
        do_reset();
        i_mem_access_mem = 1; i_mem_ready = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge i_clk);
            check($sformatf("miss%0d_stall", k), {4'd0, stalls()}, 8'h0f);
            check($sformatf("miss%0d_busy", k), {7'd0, o_busy}, {7'd0, (k > 0)});
            $display("miss cycle %0d: stall=%b busy=%b", k, stalls(), o_busy);
            tick();
        end
        i_mem_ready = 1;
        @(negedge i_clk);
        check("miss_rel_stall", {4'd0, stalls()}, 8'h00);
        check("miss_rel_busy", {7'd0, o_busy}, 8'h01);
        tick();
        i_mem_access_mem = 0;
        #1;
        check("miss_after_busy", {7'd0, o_busy}, 8'h00);
        check("miss_stall_cnt", 8'(o_stall_cycles), 8'd4);

        // Redirect held during a miss is deferred to the release cycle.
        do_reset();
        i_mem_access_mem = 1; i_mem_ready = 0; i_pc_redirect_exec = 1;
        for (int k = 0; k < 2; k++) begin
            @(negedge i_clk);
            check($sformatf("rdw%0d_flush", k), {6'd0, flushes()}, 8'h00);
            check($sformatf("rdw%0d_stall", k), {4'd0, stalls()}, 8'h0f);
            tick();
        end
        i_mem_ready = 1;
        @(negedge i_clk);
        check("rdw_rel_flush", {6'd0, flushes()}, 8'h03);
        check("rdw_rel_stall", {4'd0, stalls()}, 8'h00);
        tick();
        idle_inputs();
        #1;
        check("rdw_flush_cnt", 8'(o_flush_count), 8'd1);
        check("rdw_stall_cnt", 8'(o_stall_cycles), 8'd2);
        $display("redirect-in-wait: flush_count=%0d stall_cycles=%0d", o_flush_count, o_stall_cycles);

        // Reset in the middle of a wait aborts it.
        do_reset();
        i_mem_access_mem = 1; i_mem_ready = 0;
        tick(); tick();
        @(negedge i_clk);
        check("abort_pre_busy", {7'd0, o_busy}, 8'h01);
        i_arst = 1;
        #1;
        check("abort_rst_flush", {6'd0, flushes()}, 8'h03);
        check("abort_rst_stall", {3'd0, o_busy, stalls()}, 8'h00);
        tick();
        i_arst = 0;
        i_mem_access_mem = 0; i_mem_ready = 0;
        #1;
        check("abort_busy", {7'd0, o_busy}, 8'h00);
        check("abort_stall", {4'd0, stalls()}, 8'h00);
        check("abort_cnt", {o_stall_cycles, o_flush_count}, 8'h00);
        i_mem_ready = 1;

        // Saturation of both counters.
        do_reset();
        i_mem_access_mem = 1; i_mem_ready = 0;
        for (int k = 0; k < 20; k++) tick();
        check("sat_stall_cnt", 8'(o_stall_cycles), 8'd15);
        i_mem_access_mem = 0; i_mem_ready = 1; i_pc_redirect_exec = 1;
        tick();   // releases the wait in this cycle, redirect counted
        for (int k = 0; k < 20; k++) tick();
        check("sat_flush_cnt", 8'(o_flush_count), 8'd15);
        check("sat_stall_hold", 8'(o_stall_cycles), 8'd15);
        $display("saturation: stall_cycles=%0d flush_count=%0d", o_stall_cycles, o_flush_count);
        idle_inputs();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
